ber_checker: RTL and testbench
==============================

BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 SHALL have parameter NDELAY, default 64: number of candidate reference delays searched (0..NDELAY-1).
REQ-002 SHALL have parameter WINDOW, default 511: symbols compared per candidate delay during search.
REQ-003 SHALL have parameter CNT_NBITS, default 64: width of bit and error counters.
REQ-004 SHALL have parameter LOL_THRESH, default 64: errors per WINDOW in LOCK that declare loss of lock.
REQ-005 SHALL have port clk, input, 1: single system clock, all state on its rising edge.
REQ-006 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port enable, input, 1: block-level enable; when low all state holds.
REQ-008 SHALL have port sym_valid, input, 1: one-cycle strobe per decided symbol from the matched-filter slicer.
REQ-009 SHALL have port rx_bit, input, 1: received hard decision, sampled when sym_valid is high.
REQ-010 SHALL have port ref_bit, input, 1: transmitter PRBS reference bit, sampled when sym_valid is high.
REQ-011 SHALL have port clr, input, 1: synchronous pulse restarting search and zeroing counters.
REQ-012 SHALL have port locked, output, 1: high while in LOCK.
REQ-013 SHALL have port delay_sel, output, clog2(NDELAY): selected reference delay.
REQ-014 SHALL have port bit_count, output, CNT_NBITS: bits compared in LOCK.
REQ-015 SHALL have port err_count, output, CNT_NBITS: bit errors counted in LOCK.

Function
REQ-016 SHALL accept a symbol only when enable and sym_valid are both high ("accepted symbol"); other cycles change no state.
REQ-017 SHALL shift ref_bit into an NDELAY-deep reference delay line on every accepted symbol in all states; tap d holds the reference from d symbols earlier.
REQ-018 SHALL implement states IDLE, SEARCH, LOCK; IDLE -> SEARCH on the first accepted symbol, with candidate d=0 and window count 0.
REQ-019 SHALL, in SEARCH, compare rx_bit with tap d per accepted symbol and count mismatches over exactly WINDOW symbols, then advance d.
REQ-020 SHALL record the candidate with the lowest window error count; on ties the smallest d SHALL win.
REQ-021 SHALL, after candidate NDELAY-1 completes, load delay_sel with the best d and enter LOCK on the following cycle, with bit_count and err_count at 0.
REQ-022 SHALL, in LOCK, increment bit_count per accepted symbol and err_count when rx_bit differs from tap delay_sel.
REQ-023 SHALL update counters and outputs one clock after the accepted symbol (registered, latency 1).
REQ-024 SHALL saturate bit_count and err_count at all-ones and not wrap.
REQ-025 SHALL give clr priority over a simultaneous accepted symbol: go to SEARCH at d=0, zero counters, locked=0, delay_sel held; the delay line is not cleared.
REQ-026 SHALL not act on sym_valid with enable low, including mid-window (window resumes on re-enable).

Reset
REQ-027 SHALL, on rst asserted, asynchronously set state IDLE, locked 0, delay_sel 0, bit_count 0, err_count 0, delay line 0, all search registers 0.
REQ-028 SHALL treat rst mid-search or mid-lock identically to power-up; no partial results survive.

Configuration
REQ-029 SHALL, with macro BER_LOSS_OF_LOCK_EN defined, count errors in LOCK over consecutive WINDOW-symbol blocks and return to SEARCH (d=0, locked=0, counters held) when a block reaches LOL_THRESH errors.
REQ-030 SHALL, without BER_LOSS_OF_LOCK_EN, remain in LOCK until clr or rst, and omit the block error counter logic.

Structure
REQ-031 SHALL place the state enumeration and default parameter values (NDELAY, WINDOW, CNT_NBITS, LOL_THRESH) in shared package ber_pkg.
REQ-032 SHALL implement the reference delay line with tap multiplexer as sub-module ber_ref_delay_line; the state machine and counters stay in ber_checker.

Verification
REQ-033 SHALL cover: rx_bit = ref_bit delayed 17 symbols, no errors -> locked after 64*511 accepted symbols, delay_sel=17, err_count=0.
REQ-034 SHALL cover: delay 5, every 100th rx_bit inverted, 10000 symbols in LOCK -> bit_count=10000, err_count=100.
REQ-035 SHALL cover: ref_bit constant 0, rx_bit constant 0 (all candidates tie at 0) -> delay_sel=0.
REQ-036 SHALL cover: clr together with sym_valid mid-LOCK -> next cycle locked=0, counters 0, state SEARCH d=0; relocks to same delay.
REQ-037 SHALL cover: CNT_NBITS=8, errors on every bit in LOCK -> bit_count and err_count hold at 255.
REQ-038 SHALL cover, with BER_LOSS_OF_LOCK_EN: delay changes from 17 to 30 in LOCK -> locked falls within one window, relocks with delay_sel=30.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared definitions for the BER checker: checker states and default parameter values.
package ber_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    localparam int DEF_NDELAY     = 64;
    localparam int DEF_WINDOW     = 511;
    localparam int DEF_CNT_NBITS  = 64;
    localparam int DEF_LOL_THRESH = 64;

endpackage

// File: rtl/ber_ref_delay_line.sv
// Reference delay line with tap multiplexer: tap d is the reference bit from d symbols earlier.
module ber_ref_delay_line
    import ber_pkg::*;
#(
    parameter int NDELAY = DEF_NDELAY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift,
    input  logic                      ref_bit,
    input  logic [$clog2(NDELAY)-1:0] sel,
    output logic                      tap
);

    logic [NDELAY-2:0] taps_q;
    logic [NDELAY-1:0] line;

    // Tap 0 is the live reference bit; stored taps supply delays 1..NDELAY-1.
    assign line = {taps_q, ref_bit};
    assign tap  = line[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_q <= '0;
        end else if (shift) begin
            taps_q <= line[NDELAY-2:0];
        end
    end

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches the reference delay with fewest errors, then counts bits/errors in LOCK.
// Optional loss-of-lock detection is enabled by defining macro BER_LOSS_OF_LOCK_EN.
module ber_checker
    import ber_pkg::*;
#(
    parameter int NDELAY     = DEF_NDELAY,
    parameter int WINDOW     = DEF_WINDOW,
    parameter int CNT_NBITS  = DEF_CNT_NBITS,
    parameter int LOL_THRESH = DEF_LOL_THRESH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      sym_valid,
    input  logic                      rx_bit,
    input  logic                      ref_bit,
    input  logic                      clr,
    output logic                      locked,
    output logic [$clog2(NDELAY)-1:0] delay_sel,
    output logic [CNT_NBITS-1:0]      bit_count,
    output logic [CNT_NBITS-1:0]      err_count
);

    localparam int DW  = $clog2(NDELAY);
    localparam int WCW = $clog2(WINDOW);
    localparam int EW  = $clog2(WINDOW + 1);
    localparam logic [DW-1:0]        LAST_D  = DW'(NDELAY - 1);
    localparam logic [WCW-1:0]       LAST_W  = WCW'(WINDOW - 1);
    localparam logic [CNT_NBITS-1:0] CNT_MAX = '1;

    if (NDELAY < 2 || WINDOW < 2 || LOL_THRESH < 1) begin : g_bad_params
        $error("ber_checker: NDELAY and WINDOW must be >= 2 and LOL_THRESH >= 1");
    end

    state_t                state, state_n;
    logic [DW-1:0]         cand, cand_n, best_d, best_d_n, delay_sel_n, tap_sel;
    logic [WCW-1:0]        win_cnt, win_cnt_n;
    logic [EW-1:0]         win_err, win_err_n, best_err, best_err_n, win_err_sum;
    logic [CNT_NBITS-1:0]  bit_cnt_n, err_cnt_n;
    logic                  accept, tap, mis;

    assign accept      = enable & sym_valid;
    assign locked      = (state == ST_LOCK);
    assign tap_sel     = (state == ST_LOCK) ? delay_sel : cand;
    assign mis         = rx_bit ^ tap;
    assign win_err_sum = win_err + EW'(mis);

    ber_ref_delay_line #(.NDELAY(NDELAY)) u_ref_line (
        .clk     (clk),
        .rst     (rst),
        .shift   (accept),
        .ref_bit (ref_bit),
        .sel     (tap_sel),
        .tap     (tap)
    );

`ifdef BER_LOSS_OF_LOCK_EN
    localparam int LW = $clog2(LOL_THRESH + 1);
    logic [WCW-1:0] blk_cnt, blk_cnt_n;
    logic [LW-1:0]  blk_err, blk_err_n, blk_err_sum;

    assign blk_err_sum = blk_err + LW'(mis);
`endif

    always_comb begin
        state_n     = state;
        cand_n      = cand;
        best_d_n    = best_d;
        best_err_n  = best_err;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        delay_sel_n = delay_sel;
        bit_cnt_n   = bit_count;
        err_cnt_n   = err_count;
`ifdef BER_LOSS_OF_LOCK_EN
        blk_cnt_n   = blk_cnt;
        blk_err_n   = blk_err;
`endif
        if (enable && clr) begin
            state_n    = ST_SEARCH;
            cand_n     = '0;
            best_d_n   = '0;
            best_err_n = '0;
            win_cnt_n  = '0;
            win_err_n  = '0;
            bit_cnt_n  = '0;
            err_cnt_n  = '0;
`ifdef BER_LOSS_OF_LOCK_EN
            blk_cnt_n  = '0;
            blk_err_n  = '0;
`endif
        end else if (accept) begin
            unique case (state)
                ST_IDLE: begin
                    state_n   = ST_SEARCH;
                    cand_n    = '0;
                    win_cnt_n = '0;
                    win_err_n = '0;
                end
                ST_SEARCH: begin
                    if (win_cnt == LAST_W) begin
                        win_cnt_n = '0;
                        win_err_n = '0;
                        // Strict less-than keeps the smallest delay on ties.
                        if (cand == '0 || win_err_sum < best_err) begin
                            best_err_n = win_err_sum;
                            best_d_n   = cand;
                        end
                        if (cand == LAST_D) begin
                            state_n     = ST_LOCK;
                            delay_sel_n = best_d_n;
                            bit_cnt_n   = '0;
                            err_cnt_n   = '0;
`ifdef BER_LOSS_OF_LOCK_EN
                            blk_cnt_n   = '0;
                            blk_err_n   = '0;
`endif
                        end else begin
                            cand_n = cand + 1'b1;
                        end
                    end else begin
                        win_cnt_n = win_cnt + 1'b1;
                        win_err_n = win_err_sum;
                    end
                end
                ST_LOCK: begin
                    if (bit_count != CNT_MAX) bit_cnt_n = bit_count + 1'b1;
                    if (mis && err_count != CNT_MAX) err_cnt_n = err_count + 1'b1;
`ifdef BER_LOSS_OF_LOCK_EN
                    if (blk_err_sum >= LW'(LOL_THRESH)) begin
                        state_n    = ST_SEARCH;
                        cand_n     = '0;
                        best_d_n   = '0;
                        best_err_n = '0;
                        win_cnt_n  = '0;
                        win_err_n  = '0;
                        blk_cnt_n  = '0;
                        blk_err_n  = '0;
                    end else if (blk_cnt == LAST_W) begin
                        blk_cnt_n = '0;
                        blk_err_n = '0;
                    end else begin
                        blk_cnt_n = blk_cnt + 1'b1;
                        blk_err_n = blk_err_sum;
                    end
`endif
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cand      <= '0;
            best_d    <= '0;
            best_err  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            delay_sel <= '0;
            bit_count <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            best_d    <= best_d_n;
            best_err  <= best_err_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            delay_sel <= delay_sel_n;
            bit_count <= bit_cnt_n;
            err_count <= err_cnt_n;
        end
    end

`ifdef BER_LOSS_OF_LOCK_EN
    // Loss-of-lock error accumulation over consecutive blocks of WINDOW symbols.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
            blk_err <= '0;
        end else begin
            blk_cnt <= blk_cnt_n;
            blk_err <= blk_err_n;
        end
    end
`endif

endmodule

// File: tb/tb_ber_checker.sv
// Directed self-checking bench for ber_checker (default, small-window and 8-bit-counter instances).
// Exercises the BER_LOSS_OF_LOCK_EN path when that macro is defined.
module tb_ber_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic sym_valid = 1'b0;
    logic rx_bit = 1'b0;
    logic ref_bit = 1'b0;
    logic clr = 1'b0;

    logic        locked_a, locked_b, locked_c;
    logic [5:0]  delay_sel_a;
    logic [4:0]  delay_sel_b, delay_sel_c;
    logic [63:0] bit_count_a, err_count_a;
    logic [15:0] bit_count_b, err_count_b;
    logic [7:0]  bit_count_c, err_count_c;

    int checks = 0;
    int failures = 0;
    logic [14:0] lfsr = 15'h7FFF;
    logic [63:0] hist = '0;

    always #5 clk = ~clk;

    ber_checker dut_a (
        .clk(clk), .rst(rst), .enable(enable), .sym_valid(sym_valid), .rx_bit(rx_bit),
        .ref_bit(ref_bit), .clr(clr), .locked(locked_a), .delay_sel(delay_sel_a),
        .bit_count(bit_count_a), .err_count(err_count_a)
    );

    ber_checker #(.NDELAY(32), .WINDOW(31), .CNT_NBITS(16), .LOL_THRESH(4)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .sym_valid(sym_valid), .rx_bit(rx_bit),
        .ref_bit(ref_bit), .clr(clr), .locked(locked_b), .delay_sel(delay_sel_b),
        .bit_count(bit_count_b), .err_count(err_count_b)
    );

    ber_checker #(.NDELAY(32), .WINDOW(31), .CNT_NBITS(8), .LOL_THRESH(32)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .sym_valid(sym_valid), .rx_bit(rx_bit),
        .ref_bit(ref_bit), .clr(clr), .locked(locked_c), .delay_sel(delay_sel_c),
        .bit_count(bit_count_c), .err_count(err_count_c)
    );

    // hist[k-1] is the reference bit from k accepted symbols earlier, mirroring a zero-reset delay line.
    task automatic drive_raw(input logic r, input logic x);
        ref_bit = r;
        rx_bit = x;
        sym_valid = 1'b1;
        hist = {hist[62:0], r};
    endtask

    task automatic drive_delayed(input int k, input logic inv);
        logic r, x;
        lfsr = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        r = lfsr[0];
        x = (k == 0) ? r : hist[k-1];
        drive_raw(r, x ^ inv);
    endtask

    task automatic send_delayed(input int k, input logic inv);
        @(negedge clk);
        drive_delayed(k, inv);
    endtask

    task automatic idle();
        @(negedge clk);
        sym_valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sym_valid = 1'b0;
        clr = 1'b0;
        enable = 1'b1;
        hist = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic get_locked(input int which, output logic l);
        case (which)
            0: l = locked_a;
            1: l = locked_b;
            default: l = locked_c;
        endcase
    endtask

    // Streams symbols until the chosen instance reports lock; n is the count of symbols sent.
    task automatic run_until_lock(input int which, input int k, input logic zeros,
                                  input int max_syms, output int n);
        logic l;
        n = 0;
        while (1) begin
            @(negedge clk);
            get_locked(which, l);
            if (l || n >= max_syms) begin
                sym_valid = 1'b0;
                break;
            end
            if (zeros) drive_raw(1'b0, 1'b0);
            else drive_delayed(k, 1'b0);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (locked_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked_a: got %0d expected 0", locked_a); end
        checks++; if (delay_sel_a !== 6'd0) begin failures++; $display("[TB] FAIL reset_delay_a: got %0d expected 0", delay_sel_a); end
        checks++; if (bit_count_a !== 64'd0) begin failures++; $display("[TB] FAIL reset_bits_a: got %0d expected 0", bit_count_a); end
        checks++; if (err_count_a !== 64'd0) begin failures++; $display("[TB] FAIL reset_errs_a: got %0d expected 0", err_count_a); end
        checks++; if (locked_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked_b: got %0d expected 0", locked_b); end
        checks++; if (bit_count_b !== 16'd0) begin failures++; $display("[TB] FAIL reset_bits_b: got %0d expected 0", bit_count_b); end
        rst = 1'b0;
    endtask

    task automatic test_default_lock();
        int n;
        run_until_lock(0, 17, 1'b0, 32800, n);
        checks++; if (n != 32705) begin failures++; $display("[TB] FAIL default_lock_syms: got %0d expected 32705", n); end
        checks++; if (locked_a !== 1'b1) begin failures++; $display("[TB] FAIL default_locked: got %0d expected 1", locked_a); end
        checks++; if (delay_sel_a !== 6'd17) begin failures++; $display("[TB] FAIL default_delay: got %0d expected 17", delay_sel_a); end
        repeat (100) send_delayed(17, 1'b0);
        idle();
        checks++; if (bit_count_a !== 64'd100) begin failures++; $display("[TB] FAIL default_bits: got %0d expected 100", bit_count_a); end
        checks++; if (err_count_a !== 64'd0) begin failures++; $display("[TB] FAIL default_errs: got %0d expected 0", err_count_a); end
    endtask

    task automatic test_error_count();
        int n;
        do_reset();
        run_until_lock(1, 5, 1'b0, 1100, n);
        checks++; if (n != 993) begin failures++; $display("[TB] FAIL err_lock_syms: got %0d expected 993", n); end
        checks++; if (delay_sel_b !== 5'd5) begin failures++; $display("[TB] FAIL err_delay: got %0d expected 5", delay_sel_b); end
        for (int i = 0; i < 10000; i++) send_delayed(5, (i % 100) == 99);
        idle();
        checks++; if (bit_count_b !== 16'd10000) begin failures++; $display("[TB] FAIL err_bits: got %0d expected 10000", bit_count_b); end
        checks++; if (err_count_b !== 16'd100) begin failures++; $display("[TB] FAIL err_errs: got %0d expected 100", err_count_b); end
        checks++; if (locked_b !== 1'b1) begin failures++; $display("[TB] FAIL err_locked: got %0d expected 1", locked_b); end
    endtask

    task automatic test_clr_relock();
        int n;
        @(negedge clk);
        clr = 1'b1;
        drive_delayed(5, 1'b0);
        idle();
        checks++; if (locked_b !== 1'b0) begin failures++; $display("[TB] FAIL clr_locked: got %0d expected 0", locked_b); end
        checks++; if (bit_count_b !== 16'd0) begin failures++; $display("[TB] FAIL clr_bits: got %0d expected 0", bit_count_b); end
        checks++; if (err_count_b !== 16'd0) begin failures++; $display("[TB] FAIL clr_errs: got %0d expected 0", err_count_b); end
        checks++; if (delay_sel_b !== 5'd5) begin failures++; $display("[TB] FAIL clr_delay_held: got %0d expected 5", delay_sel_b); end
        run_until_lock(1, 5, 1'b0, 1100, n);
        checks++; if (n != 992) begin failures++; $display("[TB] FAIL clr_relock_syms: got %0d expected 992", n); end
        checks++; if (delay_sel_b !== 5'd5) begin failures++; $display("[TB] FAIL clr_relock_delay: got %0d expected 5", delay_sel_b); end
    endtask

    task automatic test_reset_mid_lock();
        repeat (20) send_delayed(5, 1'b0);
        @(negedge clk);
        sym_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (locked_b !== 1'b0) begin failures++; $display("[TB] FAIL midrst_locked: got %0d expected 0", locked_b); end
        checks++; if (bit_count_b !== 16'd0) begin failures++; $display("[TB] FAIL midrst_bits: got %0d expected 0", bit_count_b); end
        checks++; if (delay_sel_b !== 5'd0) begin failures++; $display("[TB] FAIL midrst_delay: got %0d expected 0", delay_sel_b); end
        @(negedge clk);
        hist = '0;
        rst = 1'b0;
    endtask

    task automatic test_tie_zero();
        int n;
        do_reset();
        run_until_lock(1, 0, 1'b1, 1100, n);
        checks++; if (n != 993) begin failures++; $display("[TB] FAIL tie_lock_syms: got %0d expected 993", n); end
        checks++; if (delay_sel_b !== 5'd0) begin failures++; $display("[TB] FAIL tie_delay: got %0d expected 0", delay_sel_b); end
        checks++; if (locked_b !== 1'b1) begin failures++; $display("[TB] FAIL tie_locked: got %0d expected 1", locked_b); end
    endtask

    task automatic test_enable_hold();
        int n;
        do_reset();
        repeat (400) send_delayed(9, 1'b0);
        repeat (40) begin
            @(negedge clk);
            enable = 1'b0;
            sym_valid = 1'b1;
            ref_bit = 1'($urandom & 1);
            rx_bit = 1'($urandom & 1);
        end
        @(negedge clk);
        sym_valid = 1'b0;
        enable = 1'b1;
        run_until_lock(1, 9, 1'b0, 1100, n);
        checks++; if (n != 593) begin failures++; $display("[TB] FAIL en_resume_syms: got %0d expected 593", n); end
        checks++; if (delay_sel_b !== 5'd9) begin failures++; $display("[TB] FAIL en_delay: got %0d expected 9", delay_sel_b); end
        repeat (10) send_delayed(9, 1'b0);
        repeat (10) begin
            @(negedge clk);
            enable = 1'b0;
            sym_valid = 1'b1;
            rx_bit = ~rx_bit;
        end
        idle();
        enable = 1'b1;
        checks++; if (bit_count_b !== 16'd10) begin failures++; $display("[TB] FAIL en_hold_bits: got %0d expected 10", bit_count_b); end
        checks++; if (err_count_b !== 16'd0) begin failures++; $display("[TB] FAIL en_hold_errs: got %0d expected 0", err_count_b); end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        run_until_lock(2, 3, 1'b0, 1100, n);
        checks++; if (n != 993) begin failures++; $display("[TB] FAIL sat_lock_syms: got %0d expected 993", n); end
        checks++; if (delay_sel_c !== 5'd3) begin failures++; $display("[TB] FAIL sat_delay: got %0d expected 3", delay_sel_c); end
        repeat (300) send_delayed(3, 1'b1);
        idle();
        checks++; if (bit_count_c !== 8'd255) begin failures++; $display("[TB] FAIL sat_bits: got %0d expected 255", bit_count_c); end
        checks++; if (err_count_c !== 8'd255) begin failures++; $display("[TB] FAIL sat_errs: got %0d expected 255", err_count_c); end
        checks++; if (locked_c !== 1'b1) begin failures++; $display("[TB] FAIL sat_locked: got %0d expected 1", locked_c); end
    endtask

`ifdef BER_LOSS_OF_LOCK_EN
    task automatic test_loss_of_lock();
        int n;
        logic lost;
        do_reset();
        run_until_lock(1, 17, 1'b0, 1100, n);
        checks++; if (delay_sel_b !== 5'd17) begin failures++; $display("[TB] FAIL lol_first_delay: got %0d expected 17", delay_sel_b); end
        lost = 1'b0;
        for (int i = 0; i < 32 && !lost; i++) begin
            @(negedge clk);
            if (!locked_b) lost = 1'b1;
            else if (i < 31) drive_delayed(30, 1'b0);
        end
        sym_valid = 1'b0;
        checks++; if (lost !== 1'b1) begin failures++; $display("[TB] FAIL lol_drop: got %0d expected 1", lost); end
        run_until_lock(1, 30, 1'b0, 1100, n);
        checks++; if (n != 992) begin failures++; $display("[TB] FAIL lol_relock_syms: got %0d expected 992", n); end
        checks++; if (delay_sel_b !== 5'd30) begin failures++; $display("[TB] FAIL lol_relock_delay: got %0d expected 30", delay_sel_b); end
    endtask
`else
    task automatic test_lock_persist();
        int n;
        do_reset();
        run_until_lock(1, 17, 1'b0, 1100, n);
        checks++; if (delay_sel_b !== 5'd17) begin failures++; $display("[TB] FAIL persist_delay: got %0d expected 17", delay_sel_b); end
        repeat (200) send_delayed(30, 1'b0);
        idle();
        checks++; if (locked_b !== 1'b1) begin failures++; $display("[TB] FAIL persist_locked: got %0d expected 1", locked_b); end
        checks++; if (bit_count_b !== 16'd200) begin failures++; $display("[TB] FAIL persist_bits: got %0d expected 200", bit_count_b); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_default_lock();
        test_error_count();
        test_clr_relock();
        test_reset_mid_lock();
        test_tie_zero();
        test_enable_hold();
        test_saturation();
`ifdef BER_LOSS_OF_LOCK_EN
        test_loss_of_lock();
`else
        test_lock_persist();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
